// File: rtl/mig_app_arbiter.sv
// mig_app_arbiter: round-robin whole-burst scheduler between one write client and one read
// client on the MIG 7-series app_* interface (ui_clk domain). Define MIG_ARB_STATS_EN to add
// burst/beat statistics counters.
module mig_app_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int LEN_WIDTH      = 16,
    parameter int ADDR_STEP      = 8
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic                      init_calib_complete,
    input  logic                      wr_req,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [LEN_WIDTH-1:0]      wr_len,
    input  logic [APP_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_data_req,
    output logic                      wr_busy,
    output logic                      wr_done,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [LEN_WIDTH-1:0]      rd_len,
    output logic                      rd_busy,
    output logic                      rd_done,
    output logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_data_valid,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid
`ifdef MIG_ARB_STATS_EN
    ,
    output logic [31:0]               wr_burst_cnt,
    output logic [31:0]               rd_burst_cnt,
    output logic [31:0]               rd_beat_cnt
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]                state_q, state_d;
    logic                      last_rd_q, last_rd_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic                      wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic [APP_DATA_WIDTH-1:0] rd_data_q;
    logic                      rd_valid_q;
    logic                      wr_fire, rd_fire, last, grant_wr;

    // Beat qualification: a beat issues only for a live burst with the MIG ready and calibrated
    always_comb begin
        wr_fire  = state_q == WRITE && rem_q != '0 && app_rdy && app_wdf_rdy && init_calib_complete;
        rd_fire  = state_q == READ && rem_q != '0 && app_rdy && init_calib_complete;
        last     = state_q != IDLE && (rem_q == '0 || ((wr_fire || rd_fire) && rem_q == LEN_WIDTH'(1)));
        grant_wr = wr_req && (!rd_req || last_rd_q);
    end

    // Next-state: grant in IDLE, advance address/count per beat, return to IDLE after the last beat
    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        if (state_q == IDLE) begin
            if (init_calib_complete && (wr_req || rd_req)) begin
                state_d = grant_wr ? WRITE : READ;
                addr_d  = grant_wr ? wr_addr : rd_addr;
                rem_d   = grant_wr ? wr_len : rd_len;
            end
        end else begin
            if (wr_fire || rd_fire) begin
                addr_d = addr_q + ADDR_WIDTH'(ADDR_STEP);
                rem_d  = rem_q - LEN_WIDTH'(1);
            end
            if (last) begin
                state_d   = IDLE;
                last_rd_d = state_q == READ;
            end
        end
        wr_done_d = last && state_q == WRITE;
        rd_done_d = last && state_q == READ;
    end

    // State registers; last_grant resets to READ so the first contested grant goes to the writer
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state_q    <= IDLE;
            last_rd_q  <= 1'b1;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            rd_data_q  <= app_rd_data;
            rd_valid_q <= app_rd_data_valid;
        end
    end

    assign app_en        = wr_fire || rd_fire;
    assign app_wdf_wren  = wr_fire;
    assign app_wdf_end   = wr_fire;
    assign wr_data_req   = wr_fire;
    assign app_wdf_data  = wr_fire ? wr_data : '0;
    assign app_cmd       = {2'b00, state_q == READ};
    assign app_addr      = addr_q;
    assign wr_busy       = state_q == WRITE;
    assign rd_busy       = state_q == READ;
    assign wr_done       = wr_done_q;
    assign rd_done       = rd_done_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;

`ifdef MIG_ARB_STATS_EN
    // Statistics: completed bursts per direction and returned read beats, free-running 32-bit
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
            rd_beat_cnt  <= '0;
        end else begin
            wr_burst_cnt <= wr_burst_cnt + {31'd0, wr_done_q};
            rd_burst_cnt <= rd_burst_cnt + {31'd0, rd_done_q};
            rd_beat_cnt  <= rd_beat_cnt + {31'd0, rd_valid_q};
        end
    end
`endif
endmodule

// File: tb/tb_mig_app_arbiter.sv
// tb_mig_app_arbiter: scoreboard bench for mig_app_arbiter with client, MIG and monitor processes.
module tb_mig_app_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 16;

    typedef struct {logic [AW-1:0] a; logic [LW-1:0] l;} job_t;
    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} beat_t;
    typedef struct {logic [DW-1:0] d; int c;} ret_t;

    logic          ui_clk = 0, ui_rst = 1, calib = 0;
    logic          wr_req = 0, rd_req = 0, app_rdy = 0, app_wdf_rdy = 0, app_rd_data_valid = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [LW-1:0] wr_len = '0, rd_len = '0;
    logic [DW-1:0] wr_data = '0, app_rd_data = '0;
    logic          wr_data_req, wr_busy, wr_done, rd_busy, rd_done, rd_data_valid;
    logic          app_en, app_wdf_wren, app_wdf_end;
    logic [DW-1:0] rd_data, app_wdf_data;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;

    int tests = 0, fails = 0, cyc = 0;
    int wr_fires = 0, rd_fires = 0, wr_bf = 0, rd_bf = 0, last_wr_fire = 0, last_rd_fire = 0;
    bit wr_active = 0, rd_active = 0, wr_abort = 0, pwb = 0, prb = 0;
    job_t          wr_jobs[$], rd_jobs[$];
    beat_t         exp_wr[$];
    logic [AW-1:0] exp_rdc[$];
    logic [DW-1:0] mig_pend[$];
    ret_t          exp_ret[$];
    int            done_port[$], done_cyc[$], rise_port[$], rise_cyc[$];

    mig_app_arbiter dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst), .init_calib_complete(calib),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_data_req(wr_data_req), .wr_busy(wr_busy), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    always #5 ui_clk = ~ui_clk;
    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Write client: one burst at a time, show-ahead data advanced on wr_data_req
    initial begin
        job_t j;
        logic [DW-1:0] dq[$];
        logic [AW-1:0] ta;
        int idx, n;
        bit ok;
        forever begin
            while (wr_jobs.size() == 0) begin
                @(negedge ui_clk);
                #1;
            end
            j = wr_jobs.pop_front();
            wr_active = 1;
            dq.delete();
            for (int k = 0; k < int'(j.l); k++) begin
                ta = j.a + AW'(8 * k);
                dq.push_back(rnd128());
                exp_wr.push_back(beat_t'{ta, dq[k]});
            end
            wr_addr = j.a;
            wr_len = j.l;
            idx = 0;
            wr_data = dq.size() > 0 ? dq[0] : rnd128();
            wr_req = 1;
            n = 0;
            ok = 0;
            while (1) begin
                @(negedge ui_clk);
                #1;
                if (wr_abort) break;
                if (wr_data_req) begin
                    idx++;
                    wr_data = idx < dq.size() ? dq[idx] : rnd128();
                end
                if (wr_done) begin
                    ok = 1;
                    break;
                end
                if (++n > 3000) begin
                    check("wr_timeout", 1, 0);
                    break;
                end
            end
            if (ok) check("wr_beats_left", exp_wr.size(), 0);
            else exp_wr.delete();
            wr_req = 0;
            wr_active = 0;
        end
    end

    // Read client: one burst at a time, expected command addresses queued at request time
    initial begin
        job_t j;
        logic [AW-1:0] ta;
        int n;
        bit ok;
        forever begin
            while (rd_jobs.size() == 0) begin
                @(negedge ui_clk);
                #1;
            end
            j = rd_jobs.pop_front();
            rd_active = 1;
            for (int k = 0; k < int'(j.l); k++) begin
                ta = j.a + AW'(8 * k);
                exp_rdc.push_back(ta);
            end
            rd_addr = j.a;
            rd_len = j.l;
            rd_req = 1;
            n = 0;
            ok = 0;
            while (1) begin
                @(negedge ui_clk);
                #1;
                if (rd_done) begin
                    ok = 1;
                    break;
                end
                if (++n > 3000) begin
                    check("rd_timeout", 1, 0);
                    break;
                end
            end
            if (ok) check("rd_cmds_left", exp_rdc.size(), 0);
            else exp_rdc.delete();
            rd_req = 0;
            rd_active = 0;
        end
    end

    // MIG read-data model: returns accepted reads in order after a random delay
    initial begin
        forever begin
            @(posedge ui_clk);
            #1;
            if (!ui_rst && mig_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                app_rd_data = mig_pend.pop_front();
                app_rd_data_valid = 1;
                exp_ret.push_back(ret_t'{app_rd_data, cyc});
            end else begin
                app_rd_data = rnd128();
                app_rd_data_valid = 0;
            end
        end
    end

    // Monitor: pops expected beats and returned data, checks handshake rules every cycle
    initial begin
        beat_t b;
        ret_t r;
        logic [AW-1:0] ra;
        logic wdue, rdue;
        forever begin
            @(negedge ui_clk);
            if (!ui_rst) begin
                wdue = wr_busy && exp_wr.size() > 0 && app_rdy && app_wdf_rdy && calib;
                rdue = rd_busy && exp_rdc.size() > 0 && app_rdy && calib;
                if (wr_busy && !pwb) begin
                    rise_port.push_back(0);
                    rise_cyc.push_back(cyc);
                    wr_bf = 0;
                end
                if (rd_busy && !prb) begin
                    rise_port.push_back(1);
                    rise_cyc.push_back(cyc);
                    rd_bf = 0;
                end
                check("busy_excl", wr_busy && rd_busy, 0);
                if (wr_busy) check("wr_issue", app_en, wdue);
                if (rd_busy) check("rd_issue", app_en, rdue);
                if (!wr_busy && !rd_busy) check("idle_en", app_en, 0);
                check("wdf_wren", app_wdf_wren, app_en && app_cmd == 3'd0);
                check("wdf_end", app_wdf_end, app_wdf_wren);
                check("wr_data_req", wr_data_req, app_wdf_wren);
                if (app_en && app_cmd == 3'd0) begin
                    if (exp_wr.size() == 0) check("wr_extra_beat", 1, 0);
                    else begin
                        b = exp_wr.pop_front();
                        check("wr_addr", app_addr, b.a);
                        check("wr_data", app_wdf_data, b.d);
                    end
                    wr_fires++;
                    wr_bf++;
                    last_wr_fire = cyc;
                end else if (app_en) begin
                    check("rd_cmd", app_cmd, 3'd1);
                    if (exp_rdc.size() == 0) check("rd_extra_beat", 1, 0);
                    else begin
                        ra = exp_rdc.pop_front();
                        check("rd_addr", app_addr, ra);
                    end
                    mig_pend.push_back(rnd128());
                    rd_fires++;
                    rd_bf++;
                    last_rd_fire = cyc;
                end
                if (wr_done) begin
                    check("wr_done_seq", {pwb, wr_busy}, 2'b10);
                    if (wr_bf > 0) check("wr_done_lat", cyc - last_wr_fire, 1);
                    done_port.push_back(0);
                    done_cyc.push_back(cyc);
                end
                if (rd_done) begin
                    check("rd_done_seq", {prb, rd_busy}, 2'b10);
                    if (rd_bf > 0) check("rd_done_lat", cyc - last_rd_fire, 1);
                    done_port.push_back(1);
                    done_cyc.push_back(cyc);
                end
                if (rd_data_valid) begin
                    if (exp_ret.size() == 0) check("rd_data_extra", 1, 0);
                    else begin
                        r = exp_ret.pop_front();
                        check("rd_data", rd_data, r.d);
                        check("rd_data_lat", cyc - r.c, 1);
                    end
                end else if (exp_ret.size() > 0 && exp_ret[0].c + 1 <= cyc) begin
                    r = exp_ret.pop_front();
                    check("rd_data_missing", 0, 1);
                end
            end
            pwb = wr_busy;
            prb = rd_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic c);
        app_rdy = r;
        app_wdf_rdy = w;
        calib = c;
    endtask

    task automatic wait_idle(input bit rnd);
        bit idle = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (rnd) drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0);
            idle = wr_jobs.size() == 0 && rd_jobs.size() == 0 && !wr_active && !rd_active &&
                   !wr_busy && !rd_busy && mig_pend.size() == 0 && exp_ret.size() == 0;
            if (idle) break;
        end
        if (!idle) check("drain_timeout", 0, 1);
        drive(1, 1, 1);
    endtask

    initial begin
        int f0, fa, fb;
        logic [4:0] pat;
        logic [AW-1:0] ra;
        drive(0, 0, 0);
        repeat (2) @(posedge ui_clk);
        #1;
        check("rst_app_en", app_en, 0);
        check("rst_app_addr", app_addr, 0);
        check("rst_app_cmd", app_cmd, 0);
        check("rst_wdf", {app_wdf_wren, app_wdf_end, wr_data_req}, 0);
        check("rst_wdf_data", app_wdf_data, 0);
        check("rst_busy_done", {wr_busy, rd_busy, wr_done, rd_done}, 0);
        check("rst_rd_data", {rd_data_valid, rd_data}, 0);
        @(negedge ui_clk);
        ui_rst = 0;
        drive(1, 1, 1);

        // single 4-beat write from address 0
        f0 = wr_fires;
        wr_jobs.push_back(job_t'{AW'(0), LW'(4)});
        wait_idle(0);
        check("t1_beats", wr_fires - f0, 4);
        check("t1_span", last_wr_fire - rise_cyc[$], 3);
        check("t1_done_port", done_port[$], 0);

        // both requests held from reset: alternation with one IDLE cycle between bursts
        ui_rst = 1;
        for (int k = 0; k < 2; k++) begin
            wr_jobs.push_back(job_t'{AW'(32'h1000 + 64 * k), LW'(2)});
            rd_jobs.push_back(job_t'{AW'(32'h8000 + 64 * k), LW'(2)});
        end
        repeat (3) tick();
        rise_port.delete();
        rise_cyc.delete();
        done_port.delete();
        done_cyc.delete();
        @(negedge ui_clk);
        ui_rst = 0;
        wait_idle(0);
        check("t2_bursts", rise_port.size(), 4);
        for (int i = 0; i < 4 && i < rise_port.size(); i++) check("t2_order", rise_port[i], i % 2);
        for (int i = 0; i < 3 && i + 1 < rise_cyc.size() && i < done_cyc.size(); i++)
            check("t2_idle_gap", rise_cyc[i + 1] - done_cyc[i], 1);

        // read with app_rdy toggling 1,0,1,0,1
        drive(0, 1, 1);
        rd_jobs.push_back(job_t'{AW'(0), LW'(3)});
        for (int i = 0; i < 50 && !rd_busy; i++) tick();
        f0 = rd_fires;
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            app_rdy = pat[4 - i];
            tick();
        end
        check("t3_beats", rd_fires - f0, 3);
        drive(1, 1, 1);
        wait_idle(0);
        check("t3_done_port", done_port[$], 1);

        // address wrap at the top of the address space
        wr_jobs.push_back(job_t'{AW'(28'hFFFFFF8), LW'(2)});
        wait_idle(0);
        check("t4_final_addr", app_addr, 28'h0000008);

        // zero-length write
        f0 = wr_fires;
        wr_jobs.push_back(job_t'{AW'(32'h40), LW'(0)});
        wait_idle(0);
        check("t5_len0_beats", wr_fires - f0, 0);
        check("t5_len0_done", done_cyc[$] - rise_cyc[$], 1);

        // reset mid-burst
        f0 = wr_fires;
        wr_jobs.push_back(job_t'{AW'(32'h100), LW'(8)});
        for (int i = 0; i < 100; i++) begin
            @(negedge ui_clk);
            #2;
            if (wr_fires - f0 >= 3) break;
        end
        check("t5_en_before_rst", app_en, 1);
        ui_rst = 1;
        wr_abort = 1;
        #1;
        check("t5_rst_app_en", app_en, 0);
        check("t5_rst_outs", {wr_busy, app_wdf_wren, wr_data_req, wr_done}, 0);
        check("t5_rst_addr", app_addr, 0);
        repeat (2) @(posedge ui_clk);
        @(negedge ui_clk);
        #3;
        ui_rst = 0;
        wr_abort = 0;
        check("t5_beats_at_rst", wr_fires - f0, 3);
        wait_idle(0);
        check("t5_idle_after", {wr_busy, rd_busy}, 0);

        // calibration drop for 5 cycles mid-burst
        f0 = wr_fires;
        wr_jobs.push_back(job_t'{AW'(32'h2000), LW'(8)});
        for (int i = 0; i < 100 && wr_fires - f0 < 2; i++) tick();
        calib = 0;
        fa = wr_fires;
        repeat (5) tick();
        fb = wr_fires;
        calib = 1;
        check("t6_stall", fb - fa, 0);
        wait_idle(0);
        check("t6_beats", wr_fires - f0, 8);

        // randomized traffic with random ready / calibration
        for (int it = 0; it < 15; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                ra = $urandom_range(0, 3) == 0 ? AW'(32'hFFFFFF8 - 8 * $urandom_range(0, 3)) : AW'({$urandom(), 3'b000});
                wr_jobs.push_back(job_t'{ra, LW'($urandom_range(0, 6))});
            end
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                ra = AW'({$urandom(), 3'b000});
                rd_jobs.push_back(job_t'{ra, LW'($urandom_range(0, 6))});
            end
            wait_idle(1);
        end
        check("end_queues", {exp_wr.size() == 0, exp_rdc.size() == 0, exp_ret.size() == 0}, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
